// File: rtl/simon_enc_iter_if.sv
// Block-stream interface for the iterative Simon 32/64 core.
//   in_valid/in_ready/in_dec/in_data : input handshake; in_data = {x, y}
//   out_valid/out_ready/out_data     : output handshake; same {x, y} layout
//   busy                             : core holds a block (RUN or DONE)
// master = block source/sink side, slave = cipher core.
interface simon_enc_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_dec;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_dec, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_dec, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/simon_enc_iter.sv
// Iterative Simon 32/64 encrypt/decrypt core, one round per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   key   : 32 round keys from the key schedule, key[0] = first encryption
//           round key; must stay stable from accept until out_valid
//   bus   : slave side of simon_enc_iter_if (valid/ready in and out, busy)
// Decryption reuses the encryption round: the words are swapped on load,
// the keys are walked backwards, and the words are swapped back on output.
module simon_enc_iter #(
  parameter int ROUNDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0][15:0] key,
  simon_enc_iter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Index of the final round; compared directly so ROUNDS = 32 cannot wrap.
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  logic [1:0]  state;
  logic [15:0] x_q, y_q;
  logic [4:0]  ctr_q;
  logic        dec_q;
  logic [31:0] out_q;

  logic [15:0] f_x;
  logic [15:0] x_next;
  logic        last_round;

  // f(x) = (rotl1 & rotl8) ^ rotl2, pure wiring plus two gates per bit.
  assign f_x        = ({x_q[14:0], x_q[15]} & {x_q[7:0], x_q[15:8]})
                    ^ {x_q[13:0], x_q[15:14]};
  assign x_next     = y_q ^ f_x ^ key[ctr_q];
  assign last_round = dec_q ? (ctr_q == 5'd0) : (ctr_q == LAST);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours (x/y swap relies on it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      ctr_q <= '0;
      dec_q <= 1'b0;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dec_q <= bus.in_dec;
            if (bus.in_dec) begin
              x_q   <= bus.in_data[15:0];
              y_q   <= bus.in_data[31:16];
              ctr_q <= LAST;
            end else begin
              x_q   <= bus.in_data[31:16];
              y_q   <= bus.in_data[15:0];
              ctr_q <= 5'd0;
            end
            state <= S_RUN;
          end
        end
        S_RUN: begin
          x_q <= x_next;
          y_q <= x_q;
          if (last_round) begin
            // Counter is left on its terminal index so it never leaves range.
            out_q <= dec_q ? {x_q, x_next} : {x_next, x_q};
            state <= S_DONE;
          end else begin
            ctr_q <= dec_q ? ctr_q - 5'd1 : ctr_q + 5'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_simon_enc_iter.sv
// Self-checking bench for simon_enc_iter: a 32-round and a 1-round instance,
// randomized traffic against a word-level Simon 32/64 model (including the
// key schedule), plus the directed reset, latency and backpressure cases.
module tb_simon_enc_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0][15:0] key32 = '0;
  logic [31:0][15:0] key1  = '0;

  simon_enc_iter_if ifa ();
  simon_enc_iter_if ifb ();

  simon_enc_iter #(.ROUNDS(32)) u_r32 (.clk(clk), .rst_n(rst_n), .key(key32), .bus(ifa));
  simon_enc_iter #(.ROUNDS(1))  u_r1  (.clk(clk), .rst_n(rst_n), .key(key1),  .bus(ifb));

  // Shared drivers, steered to one instance by sel (0 = 32 rounds, 1 = 1 round).
  int          sel = 0;
  logic        drv_valid = 1'b0;
  logic        drv_dec = 1'b0;
  logic [31:0] drv_data = '0;
  logic        drv_ready = 1'b0;

  assign ifa.in_valid  = drv_valid & (sel == 0);
  assign ifb.in_valid  = drv_valid & (sel == 1);
  assign ifa.out_ready = drv_ready & (sel == 0);
  assign ifb.out_ready = drv_ready & (sel == 1);
  assign ifa.in_dec    = drv_dec;
  assign ifb.in_dec    = drv_dec;
  assign ifa.in_data   = drv_data;
  assign ifb.in_data   = drv_data;

  logic        m_in_ready, m_out_valid, m_busy;
  logic [31:0] m_out_data;
  assign m_in_ready  = (sel == 1) ? ifb.in_ready  : ifa.in_ready;
  assign m_out_valid = (sel == 1) ? ifb.out_valid : ifa.out_valid;
  assign m_busy      = (sel == 1) ? ifb.busy      : ifa.busy;
  assign m_out_data  = (sel == 1) ? ifb.out_data  : ifa.out_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return 16'((v << n) | (v >> (16 - n)));
  endfunction

  function automatic logic [15:0] rf(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [31:0] model_enc(input logic [31:0] pt,
                                            input logic [31:0][15:0] k, input int rounds);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < rounds; r++) begin
      t = x;
      x = y ^ rf(x) ^ k[r];
      y = t;
    end
    return {x, y};
  endfunction

  // Genuine inverse round, keys applied last-to-first.
  function automatic logic [31:0] model_dec(input logic [31:0] ct,
                                            input logic [31:0][15:0] k, input int rounds);
    logic [15:0] x, y, px;
    x = ct[31:16];
    y = ct[15:0];
    for (int r = rounds - 1; r >= 0; r--) begin
      px = y;
      y  = x ^ rf(y) ^ k[r];
      x  = px;
    end
    return {x, y};
  endfunction

  // Simon 32/64 key schedule (m = 4, z0 stored LSB-first).
  function automatic logic [31:0][15:0] model_sched(input logic [63:0] mk);
    logic [31:0][15:0] k;
    logic [61:0] z0;
    logic [15:0] t;
    z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    for (int i = 0; i < 4; i++) k[i] = mk[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol(k[i-1], 13) ^ k[i-3];
      t = t ^ rol(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'd0, z0[i-4]} ^ 16'd3;
    end
    return k;
  endfunction

  // ---------------- transaction helpers ----------------
  task automatic send(input logic dec, input logic [31:0] din);
    @(negedge clk);
    drv_dec   = dec;
    drv_data  = din;
    drv_valid = 1'b1;
    check("in_ready_idle", {31'd0, m_in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    // Scramble the inputs while busy; the core must ignore them.
    drv_data  = $urandom;
    drv_dec   = 1'($urandom);
  endtask

  // Called at the negedge of the first cycle after accept (cycle 1).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!m_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take();
    drv_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_ready = 1'b0;
    check("out_valid_drop", {31'd0, m_out_valid}, 32'd0);
    check("in_ready_after", {31'd0, m_in_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic dec, input logic [31:0] din,
                     input logic [31:0] exp);
    int lat;
    send(dec, din);
    wait_out(lat);
    check({tag, "_lat"}, 32'(lat), (sel == 1) ? 32'd2 : 32'd33);
    check(tag, m_out_data, exp);
    take();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0][15:0] ks;
    logic [31:0] pt, ct, hold;
    logic        dec;
    int          lat;
    int          seen;

    // Reset held with random input traffic.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_valid = 1'($urandom);
      drv_data  = $urandom;
      drv_ready = 1'($urandom);
      check("rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
      check("rst_out_data", ifa.out_data, 32'd0);
      check("rst_busy", {31'd0, ifa.busy}, 32'd0);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, ifa.busy}, 32'd0);

    // Single-round instance, directed vectors.
    sel = 1;
    key1 = '0;
    txn("r1_enc", 1'b0, 32'h0001_0000, 32'h0004_0001);
    txn("r1_dec", 1'b1, 32'h0004_0001, 32'h0001_0000);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 32; j++) key1[j] = 16'($urandom);
      pt  = $urandom;
      dec = 1'($urandom);
      txn("r1_rand", dec, pt, dec ? model_dec(pt, key1, 1) : model_enc(pt, key1, 1));
    end

    // Published Simon 32/64 vector on the 32-round instance.
    sel = 0;
    key32 = model_sched(64'h1918_1110_0908_0100);
    check("sched_k0", {16'd0, key32[0]}, 32'h0100);
    txn("vec_enc", 1'b0, 32'h6565_6877, 32'hc69b_e9bb);
    txn("vec_dec", 1'b1, 32'hc69b_e9bb, 32'h6565_6877);

    // Random keys and blocks, both directions, plus round trips.
    for (int i = 0; i < 12; i++) begin
      ks = model_sched({$urandom, $urandom});
      key32 = ks;
      pt  = $urandom;
      dec = 1'($urandom);
      ct  = dec ? model_dec(pt, ks, 32) : model_enc(pt, ks, 32);
      txn("r32_rand", dec, pt, ct);
      txn("r32_back", ~dec, ct, pt);
    end

    // Backpressure in DONE.
    pt = $urandom;
    ct = model_enc(pt, key32, 32);
    send(1'b0, pt);
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'd33);
    hold = m_out_data;
    check("bp_data", hold, ct);
    for (int i = 0; i < 10; i++) begin
      drv_valid = (i == 4);
      drv_data  = ~pt;
      @(posedge clk);
      @(negedge clk);
      drv_valid = 1'b0;
      check("bp_hold", m_out_data, ct);
      check("bp_in_ready", {31'd0, m_in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, m_out_valid}, 32'd1);
    end
    take();
    @(posedge clk);
    @(negedge clk);
    check("bp_not_consumed", {31'd0, m_busy}, 32'd0);

    // Reset mid-run at round 15.
    send(1'b0, $urandom);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, ifa.busy}, 32'd0);
    check("abort_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("abort_out_data", ifa.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    key32 = '0;
    txn("after_abort", 1'b0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
